// File: rtl/vdp_tile_render.sv
// rtl/vdp_tile_render.sv - Graphics-I tile fetch and pixel stage, 2x scaled and centred
//
// Purpose: sits after the VGA sync generator. For each tile-area row it fetches
// name, pattern and colour bytes from VRAM, one tile ahead of display, and shifts
// the pattern out with every pixel doubled. The border gets the backdrop colour.
// color, vid_active, hsync and vsync are the inputs delayed by exactly 2 clocks.
//
// Ports:
//   clk, reset                     pixel clock, synchronous active-high reset
//   col, row                       current pixel position from the sync generator
//   vid_active_in, hsync_in,
//   vsync_in                       timing flags from the sync generator
//   name_base, pattern_base,
//   color_base, backdrop           table bases and border colour
//   vram_addr, vram_rd, vram_data  VRAM read port (data one clock after vram_rd)
//   color, vid_active, hsync,
//   vsync                          pixel colour index and delayed timing flags

module vdp_tile_render #(
   parameter int HSTART   = 64,
   parameter int VSTART   = 48,
   parameter int COL_BITS = 10,
   parameter int ROW_BITS = 10
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [COL_BITS-1:0] col,
   input  logic [ROW_BITS-1:0] row,
   input  logic                vid_active_in,
   input  logic                hsync_in,
   input  logic                vsync_in,
   input  logic [3:0]          name_base,
   input  logic [2:0]          pattern_base,
   input  logic [7:0]          color_base,
   input  logic [3:0]          backdrop,
   output logic [13:0]         vram_addr,
   output logic                vram_rd,
   input  logic [7:0]          vram_data,
   output logic [3:0]          color,
   output logic                vid_active,
   output logic                hsync,
   output logic                vsync
);

   localparam logic [COL_BITS-1:0] H_LO   = COL_BITS'(HSTART);
   localparam logic [COL_BITS-1:0] F_LO   = COL_BITS'(HSTART - 16);
   localparam logic [COL_BITS-1:0] H_SPAN = COL_BITS'(512);
   localparam logic [ROW_BITS-1:0] V_LO   = ROW_BITS'(VSTART);
   localparam logic [ROW_BITS-1:0] V_SPAN = ROW_BITS'(384);

   logic [COL_BITS-1:0] x_full;
   logic [COL_BITS-1:0] f_full;
   logic [ROW_BITS-1:0] y_full;
   logic                in_rows;
   logic                in_area;
   logic                in_fetch;
   logic [3:0]          phase;
   logic [4:0]          tx;
   logic [7:0]          y;
   logic                load;
   logic [13:0]         fetch_addr;
   logic [3:0]          pix_c;

   logic [13:0] addr_hold;
   logic [7:0]  name_reg;
   logic [7:0]  pat_stage;
   logic [7:0]  col_stage;
   logic [7:0]  shift_reg;
   logic [7:0]  disp_col;
   logic        vid_d1;
   logic        hs_d1;
   logic        vs_d1;
   logic        area_d1;

   assign x_full = col - H_LO;
   assign f_full = col - F_LO;
   assign y_full = row - V_LO;

   assign in_rows  = (row >= V_LO) && (y_full < V_SPAN);
   assign in_area  = in_rows && (col >= H_LO) && (x_full < H_SPAN);
   // The fetch window runs one tile (16 clocks) ahead of the tile area.
   // Reset gates it so no read strobe escapes while state is being cleared.
   assign in_fetch = in_rows && (col >= F_LO) && (f_full < H_SPAN) && !reset;

   assign phase = f_full[3:0];
   assign tx    = f_full[8:4];
   assign y     = y_full[8:1];
   assign load  = in_area && (x_full[3:0] == 4'd0);

   always_comb begin
      fetch_addr = {color_base, 1'b0, name_reg[7:3]};
      case (phase)
         4'd0:    fetch_addr = {name_base, y[7:3], tx};
         4'd2:    fetch_addr = {pattern_base, name_reg, y[2:0]};
         default: fetch_addr = {color_base, 1'b0, name_reg[7:3]};
      endcase
   end

   assign vram_rd   = in_fetch && ((phase == 4'd0) || (phase == 4'd2) || (phase == 4'd4));
   assign vram_addr = vram_rd ? fetch_addr : addr_hold;

   assign pix_c = shift_reg[7] ? disp_col[7:4] : disp_col[3:0];

   always_ff @(posedge clk) begin
      if (reset) begin
         addr_hold  <= '0;
         name_reg   <= '0;
         pat_stage  <= '0;
         col_stage  <= '0;
         shift_reg  <= '0;
         disp_col   <= '0;
         vid_d1     <= 1'b0;
         hs_d1      <= 1'b0;
         vs_d1      <= 1'b0;
         area_d1    <= 1'b0;
         color      <= '0;
         vid_active <= 1'b0;
         hsync      <= 1'b0;
         vsync      <= 1'b0;
      end else begin
         if (vram_rd)
            addr_hold <= fetch_addr;

         // Odd phases capture the byte requested on the previous clock.
         if (in_fetch) begin
            case (phase)
               4'd1:    name_reg  <= vram_data;
               4'd3:    pat_stage <= vram_data;
               4'd5:    col_stage <= vram_data;
               default: ;
            endcase
         end

         // The load clock shows pattern bit 7; each later even offset moves
         // one bit on, so every pattern bit covers two output pixels.
         if (load) begin
            shift_reg <= pat_stage;
            disp_col  <= col_stage;
         end else if (!x_full[0]) begin
            shift_reg <= {shift_reg[6:0], 1'b0};
         end

         vid_d1  <= vid_active_in;
         hs_d1   <= hsync_in;
         vs_d1   <= vsync_in;
         area_d1 <= in_area;

         vid_active <= vid_d1;
         hsync      <= hs_d1;
         vsync      <= vs_d1;
         if (!vid_d1)
            color <= 4'd0;
         else if (!area_d1 || (pix_c == 4'd0))
            color <= backdrop;
         else
            color <= pix_c;
      end
   end

endmodule

// File: tb/tb_vdp_tile_render.sv
// tb/tb_vdp_tile_render.sv - self-checking bench for vdp_tile_render against a pixel model
//
// Purpose: sweeps whole scan lines over selected rows, serves VRAM from a byte
// array, and compares every output pixel, timing flag and VRAM request with a
// model that derives each pixel directly from the Graphics-I table layout.
// Ports: none (top-level bench).

module tb_vdp_tile_render;

   typedef struct packed {
      int color;
      int sync;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [9:0]  col = '0;
   logic [9:0]  row = '0;
   logic        vid_active_in = 1'b0;
   logic        hsync_in = 1'b0;
   logic        vsync_in = 1'b0;
   logic [3:0]  name_base = '0;
   logic [2:0]  pattern_base = '0;
   logic [7:0]  color_base = '0;
   logic [3:0]  backdrop = '0;
   logic [13:0] vram_addr;
   logic        vram_rd;
   logic [7:0]  vram_data = '0;
   logic [3:0]  color;
   logic        vid_active;
   logic        hsync;
   logic        vsync;

   logic [7:0] mem [0:16383];

   int   n_checks = 0;
   int   n_pass = 0;
   exp_t h0 = '0;
   exp_t h1 = '0;
   int   rst_row = -1;
   int   blank_end = 0;

   always #20 clk = ~clk;

   always @(posedge clk)
      if (vram_rd) vram_data <= mem[vram_addr];

   vdp_tile_render #(
      .HSTART(64), .VSTART(48), .COL_BITS(10), .ROW_BITS(10)
   ) dut (
      .clk(clk), .reset(reset), .col(col), .row(row),
      .vid_active_in(vid_active_in), .hsync_in(hsync_in), .vsync_in(vsync_in),
      .name_base(name_base), .pattern_base(pattern_base), .color_base(color_base),
      .backdrop(backdrop), .vram_addr(vram_addr), .vram_rd(vram_rd),
      .vram_data(vram_data), .color(color), .vid_active(vid_active),
      .hsync(hsync), .vsync(vsync)
   );

   task automatic check(input string tag, input int obs, input int expv);
      n_checks++;
      if (obs == expv) n_pass++;
      else $display("FAIL %s at col %0d row %0d: got 0x%0h expected 0x%0h", tag, col, row, obs, expv);
   endtask

   function automatic int model_color(input int c, input int r);
      int x, y, nm, pt, cb, ci;
      if (!(c < 640 && r < 480)) return 0;
      if (!(c >= 64 && c < 576 && r >= 48 && r < 432)) return int'(backdrop);
      if (r == rst_row && c < blank_end) return int'(backdrop);
      x  = (c - 64) / 2;
      y  = (r - 48) / 2;
      nm = int'(mem[int'(name_base) * 1024 + (y / 8) * 32 + x / 8]);
      pt = int'(mem[int'(pattern_base) * 2048 + nm * 8 + y % 8]);
      cb = int'(mem[int'(color_base) * 64 + nm / 8]);
      ci = ((pt >> (7 - x % 8)) & 1) != 0 ? (cb >> 4) : (cb & 15);
      return (ci == 0) ? int'(backdrop) : ci;
   endfunction

   function automatic int model_rd(input int c, input int r);
      int p;
      if (!(r >= 48 && r < 432 && c >= 48 && c < 560)) return 0;
      p = (c - 48) % 16;
      return (p == 0 || p == 2 || p == 4) ? 1 : 0;
   endfunction

   function automatic int model_addr(input int c, input int r);
      int p, tx, y, na, nm;
      p  = (c - 48) % 16;
      tx = (c - 48) / 16;
      y  = (r - 48) / 2;
      na = int'(name_base) * 1024 + (y / 8) * 32 + tx;
      if (p == 0) return na;
      nm = int'(mem[na]);
      if (p == 2) return int'(pattern_base) * 2048 + nm * 8 + y % 8;
      return int'(color_base) * 64 + nm / 8;
   endfunction

   task automatic cycle(input int c, input int r, input bit rst);
      int k;
      @(negedge clk);
      check("color", int'(color), h1.color);
      check("syncs", int'({vid_active, hsync, vsync}), h1.sync);
      h1 = h0;
      col           = 10'(c);
      row           = 10'(r);
      vid_active_in = (c < 640 && r < 480);
      hsync_in      = (c >= 656 && c < 752);
      vsync_in      = (r >= 490 && r < 492);
      reset         = rst;
      if (rst) begin
         h0 = '0;
         h1 = '0;
         rst_row = r;
         k = (c >= 48) ? (c - 48) / 16 + 1 : 0;
         blank_end = 64 + 16 * k;
      end else begin
         h0.color = model_color(c, r);
         h0.sync  = int'({vid_active_in, hsync_in, vsync_in});
      end
      #1;
      if (rst) begin
         check("rd_in_reset", int'(vram_rd), 0);
      end else begin
         check("vram_rd", int'(vram_rd), model_rd(c, r));
         if (model_rd(c, r) != 0) check("vram_addr", int'(vram_addr), model_addr(c, r));
      end
   endtask

   task automatic run_row(input int r, input int rst_col);
      rst_row = -1;
      for (int c = 0; c < 800; c++) cycle(c, r, c == rst_col);
   endtask

   task automatic fill_mem(input bit rnd);
      for (int i = 0; i < 16384; i++) mem[i] = rnd ? 8'($urandom) : 8'h00;
   endtask

   task automatic rand_regs();
      name_base    = 4'($urandom);
      pattern_base = 3'($urandom);
      color_base   = 8'($urandom);
      backdrop     = 4'($urandom);
   endtask

   initial begin
      int rows_all0 [7] = '{10, 47, 48, 200, 431, 432, 490};
      int rows_edge [5] = '{47, 48, 49, 431, 432};

      fill_mem(1'b0);
      for (int i = 0; i < 3; i++) cycle(0, 0, 1'b1);
      @(posedge clk);
      #1;
      check("rst_color", int'(color), 0);
      check("rst_vid", int'(vid_active), 0);
      check("rst_hsync", int'(hsync), 0);
      check("rst_vsync", int'(vsync), 0);
      check("rst_vram_rd", int'(vram_rd), 0);
      check("rst_vram_addr", int'(vram_addr), 0);

      // Blank VRAM: every active pixel falls back to the backdrop.
      backdrop = 4'd4;
      foreach (rows_all0[i]) run_row(rows_all0[i], -1);

      // Directed tiles: name fetch 0x400, pattern 0x28, colour 0x800.
      name_base    = 4'd1;
      pattern_base = 3'd0;
      color_base   = 8'h20;
      backdrop     = 4'd7;
      mem[14'h0400] = 8'h05;
      mem[14'h0028] = 8'hF0;
      mem[14'h0800] = 8'h1F;
      mem[14'h0401] = 8'h48;
      mem[14'h0240] = 8'hAA;
      mem[14'h0809] = 8'h0A;
      run_row(48, -1);
      run_row(49, -1);

      // Random VRAM and table bases.
      fill_mem(1'b1);
      foreach (rows_edge[i]) begin
         rand_regs();
         run_row(rows_edge[i], -1);
      end
      for (int i = 0; i < 18; i++) begin
         rand_regs();
         run_row($urandom_range(0, 524), -1);
      end

      // Reset mid-line, then a clean line.
      rand_regs();
      run_row(100, 300);
      run_row(101, -1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
